// File: rtl/priority_arbiter_pkg.sv
// Shared types and helpers for the priority_arbiter block.
package priority_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Binary index width for a given requester count (never below 1 bit).
  function automatic int idx_width(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/lsb_isolate.sv
// Combinational lowest-set-bit isolation: one-hot result, binary index, zero flag.
module lsb_isolate
  import priority_arbiter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]            vec_i,
  output logic [WIDTH-1:0]            onehot_o,
  output logic [idx_width(WIDTH)-1:0] idx_o,
  output logic                        zero_o
);

  localparam int IDX_W = idx_width(WIDTH);

  assign onehot_o = vec_i & (~vec_i + WIDTH'(1));
  assign zero_o   = (vec_i == '0);

  // NOTE: idx_o gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (onehot_o[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/priority_arbiter.sv
// One-hot registered grant arbiter with hold timeout.
// Define PRIORITY_ARBITER_RR_EN for round-robin selection; default is fixed priority.
module priority_arbiter
  import priority_arbiter_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic                        clk_i,
  input  logic                        arstn_i,
  input  logic [WIDTH-1:0]            req_i,
  input  logic [WIDTH-1:0]            done_i,
  output logic [WIDTH-1:0]            gnt_o,
  output logic [idx_width(WIDTH)-1:0] gnt_idx_o,
  output logic                        gnt_val_o,
  output logic                        timeout_o
);

  localparam int IDX_W = idx_width(WIDTH);
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  arb_state_t       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_gnt, w_gnt_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_val, r_timeout, w_timeout_nxt;

  logic [WIDTH-1:0] w_win_oh;
  logic [IDX_W-1:0] w_win_idx;
  logic             w_release;

`ifdef PRIORITY_ARBITER_RR_EN
  logic [IDX_W-1:0] r_last;
  logic [WIDTH-1:0] w_mask, w_oh_m, w_oh_u;
  logic [IDX_W-1:0] w_idx_m, w_idx_u;
  logic             w_zero_m, w_zero_u;

  // Only requesters strictly above the previous owner get first pick.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < WIDTH; i++) w_mask[i] = (i > int'(r_last));
  end

  lsb_isolate #(.WIDTH(WIDTH)) u_iso_masked (
    .vec_i(req_i & w_mask), .onehot_o(w_oh_m), .idx_o(w_idx_m), .zero_o(w_zero_m)
  );
  lsb_isolate #(.WIDTH(WIDTH)) u_iso_plain (
    .vec_i(req_i), .onehot_o(w_oh_u), .idx_o(w_idx_u), .zero_o(w_zero_u)
  );

  assign w_win_oh  = w_zero_m ? w_oh_u  : w_oh_m;
  assign w_win_idx = w_zero_m ? w_idx_u : w_idx_m;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i)                                r_last <= IDX_W'(WIDTH - 1);
    else if (r_state == ARB_IDLE && |req_i)      r_last <= w_win_idx;
  end
`else
  logic w_zero_u;

  lsb_isolate #(.WIDTH(WIDTH)) u_iso_plain (
    .vec_i(req_i), .onehot_o(w_win_oh), .idx_o(w_win_idx), .zero_o(w_zero_u)
  );
`endif

  assign w_release = done_i[r_idx] | ~req_i[r_idx];

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_idx_nxt     = r_idx;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (|req_i) begin
          w_state_nxt = ARB_GRANT;
          w_gnt_nxt   = w_win_oh;
          w_idx_nxt   = w_win_idx;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      ARB_GRANT: begin
        // Release outranks expiry, so a same-cycle done never reports a timeout.
        if (w_release || r_cnt == CNT_W'(MAX_HOLD)) begin
          w_state_nxt   = ARB_IDLE;
          w_gnt_nxt     = '0;
          w_idx_nxt     = '0;
          w_cnt_nxt     = '0;
          w_timeout_nxt = ~w_release;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_gnt_nxt   = '0;
        w_idx_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state   <= ARB_IDLE;
      r_gnt     <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_val     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_idx     <= w_idx_nxt;
      r_cnt     <= w_cnt_nxt;
      r_val     <= |w_gnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign gnt_o     = r_gnt;
  assign gnt_idx_o = r_idx;
  assign gnt_val_o = r_val;
  assign timeout_o = r_timeout;

endmodule

// File: tb/tb_priority_arbiter.sv
// Randomised and directed self-checking bench for priority_arbiter against a behavioural model.
module tb_priority_arbiter;

  localparam int W  = 16;
  localparam int MH = 8;

  logic          clk_i = 1'b0;
  logic          arstn_i;
  logic [W-1:0]  req_i, done_i, gnt_o;
  logic [3:0]    gnt_idx_o;
  logic          gnt_val_o, timeout_o;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: owner index (-1 = idle), cycles held, timeout flag, last owner.
  int m_owner, m_held, m_last;
  bit m_to;

  priority_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i), .req_i(req_i), .done_i(done_i),
    .gnt_o(gnt_o), .gnt_idx_o(gnt_idx_o), .gnt_val_o(gnt_val_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [W-1:0] req);
`ifdef PRIORITY_ARBITER_RR_EN
    for (int k = 1; k <= W; k++) begin
      int i = (m_last + k) % W;
      if (req[i]) return i;
    end
`else
    for (int i = 0; i < W; i++) if (req[i]) return i;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_to = 0; m_last = W - 1;
  endtask

  task automatic model_step(input logic [W-1:0] req, input logic [W-1:0] done);
    m_to = 0;
    if (m_owner < 0) begin
      if (req != 0) begin
        m_owner = pick(req); m_held = 1; m_last = m_owner;
      end
    end else if (done[m_owner] || !req[m_owner]) begin
      m_owner = -1;
    end else if (m_held == MH) begin
      m_owner = -1; m_to = 1;
    end else begin
      m_held++;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [W-1:0] exp_gnt;
    exp_gnt = (m_owner < 0) ? '0 : (W'(1) << m_owner);
    check({tag, ".gnt"}, 32'(gnt_o), 32'(exp_gnt));
    check({tag, ".idx"}, 32'(gnt_idx_o), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check({tag, ".val"}, 32'(gnt_val_o), 32'(m_owner >= 0));
    check({tag, ".to"},  32'(timeout_o), 32'(m_to));
  endtask

  // Starts and ends just after a falling edge.
  task automatic cycle(input string tag, input logic [W-1:0] req, input logic [W-1:0] done);
    req_i = req; done_i = done;
    @(posedge clk_i);
    model_step(req, done);
    @(negedge clk_i);
    check_outputs(tag);
  endtask

  // Owner raises done after 'hold' cycles; used for the round-robin and fixed-priority scenarios.
  task automatic run_release_after(input string tag, input logic [W-1:0] req, input int hold, input int n);
    for (int c = 0; c < n; c++)
      cycle(tag, req, (m_owner >= 0 && m_held == hold) ? (W'(1) << m_owner) : '0);
  endtask

  initial begin
    int hi_run, to_seen;
    logic [W-1:0] r, d;

    model_reset();
    arstn_i = 1'b0; req_i = '1; done_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_outputs("reset_hold");
    arstn_i = 1'b1; req_i = '0;
    cycle("reset_idle", '0, '0);
    cycle("reset_idle", '0, '0);

    cycle("single", 16'h0020, '0);
    check("single_idx5", 32'(gnt_idx_o), 32'd5);
    cycle("single_rel", 16'h0020, 16'h0020);
    check("single_drop", 32'(gnt_o), 32'd0);
    cycle("single_gap", '0, '0);

    run_release_after("rr", 16'h0003, 2, 12);
    cycle("rr_idle", '0, '0);

    hi_run = 0; to_seen = 0;
    for (int c = 0; c < 2 * MH + 4; c++) begin
      cycle("tmo", 16'h0004, '0);
      if (to_seen == 0) begin
        if (gnt_o == 16'h0004) hi_run++;
        if (timeout_o) to_seen = 1;
      end
    end
    check("tmo_window", 32'(hi_run), 32'(MH));
    check("tmo_pulse", 32'(to_seen), 32'd1);
    cycle("tmo_idle", '0, '0);

    for (int c = 0; c < MH + 2; c++)
      cycle("collide", 16'h0004, (m_owner >= 0 && m_held == MH) ? 16'h0004 : '0);
    cycle("collide_idle", '0, '0);

    cycle("mid_reset", 16'h0100, '0);
    cycle("mid_reset", 16'h0100, '0);
    #2 arstn_i = 1'b0;
    #1;
    model_reset();
    check("async_gnt", 32'(gnt_o), 32'd0);
    check("async_val", 32'(gnt_val_o), 32'd0);
    check("async_idx", 32'(gnt_idx_o), 32'd0);
    @(negedge clk_i);
    check_outputs("in_reset");
    arstn_i = 1'b1;
    cycle("post_reset", '0, '0);

    run_release_after("pri", 16'h8001, 1, 12);
    cycle("pri_idle", '0, '0);

    for (int c = 0; c < 400; c++) begin
      r = W'($urandom) & W'($urandom);
      if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
      d = W'($urandom) & W'($urandom) & W'($urandom);
      cycle("rand", r, d);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/priority_arbiter.md
# priority_arbiter

Arbitrates WIDTH requesters for one shared resource (e.g. a downstream datapath or bus port) and issues one registered one-hot grant at a time. Winner selection uses lowest-set-bit isolation, optionally rotated for round-robin fairness. Grants are held until the owner releases or a hold timeout expires. The block sits in front of any shared unit that several agents raise requests for.

## Interface
- `WIDTH`, default 16: number of requesters; must be ≥ 2.
- `MAX_HOLD`, default 8: maximum consecutive cycles one owner may hold a grant; must be ≥ 1.
- `clk_i` input 1: clock; all logic is on the rising edge.
- `arstn_i` input 1: reset. Asynchronous, active-low.
- `req_i` input WIDTH: request vector, one bit per requester; level-sensitive.
- `done_i` input WIDTH: release strobe; only the owner's bit is examined.
- `gnt_o` output WIDTH: registered one-hot grant; all zero when idle.
- `gnt_idx_o` output $clog2(WIDTH): binary index of the owner; 0 when idle.
- `gnt_val_o` output 1: high while any grant is asserted; equals |gnt_o.
- `timeout_o` output 1: one-cycle pulse, concurrent with the grant drop caused by hold expiry.

## Operation
- FSM has two states.
  - IDLE: gnt_o = 0.
  - GRANT: gnt_o is one-hot.
- IDLE transitions:
  - req_i == 0: stay in IDLE.
  - Otherwise: at the next edge, go to GRANT with gnt_o = winner, gnt_idx_o = index of the winner, hold counter = 1, and last_owner = winner.
- GRANT, evaluated every cycle, in priority order:
  1. Release: done_i[owner] = 1 or req_i[owner] = 0. At the next edge, go to IDLE and drop the grant; timeout_o = 0.
  2. Expiry: counter == MAX_HOLD. At the next edge, go to IDLE, drop the grant, and set timeout_o = 1 for one cycle.
  3. Otherwise: counter increments and the grant is held.
- Non-owner done_i bits are ignored.
- Request changes by non-owners never preempt the current owner.
- The owner holds for at most MAX_HOLD cycles.
- One dead IDLE cycle always separates two grants.
- Winner selection uses lowest-set-bit isolation: sel = req & (~req + 1), truncated to WIDTH.
- Round-robin selection, when `PRIORITY_ARBITER_RR_EN` is defined:
  - mask = bits strictly above the index of last_owner.
  - If (req_i & mask) ≠ 0, winner = lowest set bit of (req_i & mask).
  - Otherwise, winner = lowest set bit of req_i (wrap-around).
- Counter width is $clog2(MAX_HOLD+1). It never exceeds MAX_HOLD.
- Reset (asynchronous assert, any state, including mid-grant):
  - state = IDLE, gnt_o = 0, gnt_idx_o = 0, gnt_val_o = 0, timeout_o = 0, counter = 0.
  - last_owner = WIDTH-1, so the first round-robin pick is the lowest requesting index.

## Timing
- Latency from request to grant is 1 cycle: req_i is sampled in IDLE at edge N, and gnt_o is valid after edge N.
- Latency from release to drop is 1 cycle: done_i is seen in cycle K, and gnt_o is 0 after edge K.
- A new grant is possible after edge K+1 at the earliest.
- A single owner with continuous requests gets a MAX_HOLD-cycle grant window followed by a 1-cycle gap.
- All outputs are registered; there is no combinational path from input to output.
- If done_i and expiry occur in the same cycle, it is a release: timeout_o stays 0.

## Configuration
- Macro: `PRIORITY_ARBITER_RR_EN`.
- Defined: round-robin selection as described above. A timed-out or released owner drops to lowest priority.
- Undefined: fixed priority; the lowest requesting index always wins. last_owner is unused and may be optimised away. A timed-out owner can be re-granted after the 1-cycle gap if it is still the lowest requester.

## Structure
- Package `priority_arbiter_pkg` contains:
  - The state enum `arb_state_t` {ARB_IDLE, ARB_GRANT}.
  - A localparam function for the index width.
- One sub-module, `lsb_isolate`:
  - Parameterised by WIDTH; purely combinational.
  - Returns the lowest set bit one-hot plus its binary index, and a zero flag.
  - Instantiated twice in round-robin mode (masked and unmasked); the result is selected on (req_i & mask) ≠ 0.

## Test plan
- Reset values: hold arstn_i = 0 with req_i = 16'hFFFF → all outputs 0. Release reset with req_i = 16'h0000 → outputs stay 0.
- Single requester: req_i = 16'h0020 → gnt_o = 16'h0020 and gnt_idx_o = 5 after 1 edge. Pulse done_i[5] → gnt_o = 0 on the next edge, and timeout_o never asserts.
- Round robin (RR_EN defined): req_i = 16'h0003 held, owners release after 2 cycles → grant sequence 0, 1, 0, 1, each separated by 1 IDLE cycle.
- Timeout: MAX_HOLD = 8, req_i = 16'h0004 held, done_i = 0 → gnt_o high for exactly 8 cycles, then 0 with timeout_o = 1 for 1 cycle, then re-granted.
- Release/expiry collision and reset mid-grant:
  - done_i[owner] asserted in the counter == MAX_HOLD cycle → timeout_o stays 0.
  - arstn_i asserted during GRANT → gnt_o = 0 immediately, without waiting for a clock edge.
- Fixed priority (RR_EN undefined): req_i = 16'h8001 held, with each owner releasing → index 0 wins every time, and bit 15 is never granted.
